// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (fixed priority) and a FIFO-buffered AUX requester.
// Zero-latency combinational write port; AUX is held off by aux_ready and a starvation stall request.
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        rd_busy1,
  output logic        rd_busy2,
  output logic        stall_req,
  output logic [3:0]  pending_cnt,
  output logic        idle
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0]     DEPTH_C = 4'(DEPTH);
  localparam logic [AGW-1:0] LIMIT_C = AGW'(STARVE_LIMIT);

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic [AGW-1:0]   age_q, age_d;

  logic full, empty, wb_valid, head_live, head_kill, push, pop;
  logic busy1_raw, busy2_raw;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == 4'd0);
  assign wb_valid  = !reset && wb_we && (wb_addr != 5'd0);
  assign head_live = !empty && live_q[rd_ptr_q];
  assign head_kill = wb_valid && head_live && (addr_q[rd_ptr_q] == wb_addr);
  assign aux_ready = !reset && !full;
  // Writes to $0 are acknowledged but never occupy a slot.
  assign push      = aux_valid && aux_ready && (aux_addr != 5'd0);
  // A dead head drains without using the port, so it pops even under a WB write.
  assign pop       = !reset && !empty && !(wb_valid && head_live);

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (wb_valid) begin
      rf_we   = 1'b1;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (!reset && head_live) begin
      rf_we   = 1'b1;
      rf_addr = addr_q[rd_ptr_q];
      rf_data = data_q[rd_ptr_q];
    end
  end

  // Order matters: a same-cycle push to the WB register is newer and must stay live.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_valid && (addr_q[i] == wb_addr)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[rd_ptr_q] = 1'b0;
    if (push) live_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + {3'b000, push} - {3'b000, pop};
    age_d    = age_q;
    if (pop || empty || !head_live || head_kill) age_d = '0;
    else if (age_q < LIMIT_C)                     age_d = age_q + AGW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      live_q   <= '0;
      age_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
      age_q    <= age_d;
      if (push) begin
        addr_q[wr_ptr_q] <= aux_addr;
        data_q[wr_ptr_q] <= aux_data;
      end
    end
  end

  always_comb begin
    busy1_raw = 1'b0;
    busy2_raw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == rd_addr1)) busy1_raw = 1'b1;
      if (live_q[i] && (addr_q[i] == rd_addr2)) busy2_raw = 1'b1;
    end
  end

  assign rd_busy1    = !reset && (rd_addr1 != 5'd0) && busy1_raw;
  assign rd_busy2    = !reset && (rd_addr2 != 5'd0) && busy2_raw;
  assign stall_req   = !reset && head_live && (age_q >= LIMIT_C);
  assign pending_cnt = reset ? 4'd0 : count_q;
  assign idle        = reset || empty;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: inputs change 1 time unit after posedge, outputs checked 1 unit later.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        rd_busy1, rd_busy2;
  logic        stall_req;
  logic [3:0]  pending_cnt;
  logic        idle;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .stall_req(stall_req), .pending_cnt(pending_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h77;
    aux_valid = 1'b1; aux_addr = 5'd4; aux_data = 32'h66;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    settle();
    chk("rst_rf_we",     32'(rf_we), 0);
    chk("rst_aux_ready", 32'(aux_ready), 0);
    chk("rst_idle",      32'(idle), 1);
    chk("rst_pending",   32'(pending_cnt), 0);
    chk("rst_stall",     32'(stall_req), 0);
    cyc(); cyc();
    reset = 1'b0; wb_we = 1'b0; aux_valid = 1'b0;

    // 1: WB write passes straight through
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
    settle();
    chk("t1_rf_we",   32'(rf_we), 1);
    chk("t1_rf_addr", 32'(rf_addr), 5);
    chk("t1_rf_data", rf_data, 32'h11);
    chk("t1_idle",    32'(idle), 1);
    cyc();
    wb_we = 1'b0;

    // 2: AUX r7 then r8, drained one cycle after each push
    aux_valid = 1'b1; aux_addr = 5'd7; aux_data = 32'hA;
    settle();
    chk("t2_ready0", 32'(aux_ready), 1);
    chk("t2_idle0",  32'(rf_we), 0);
    cyc();
    aux_addr = 5'd8; aux_data = 32'hB; rd_addr1 = 5'd7; rd_addr2 = 5'd8;
    settle();
    chk("t2_r7_we",   32'(rf_we), 1);
    chk("t2_r7_addr", 32'(rf_addr), 7);
    chk("t2_r7_data", rf_data, 32'hA);
    chk("t2_busy7",   32'(rd_busy1), 1);
    chk("t2_busy8",   32'(rd_busy2), 0);
    chk("t2_pend1",   32'(pending_cnt), 1);
    cyc();
    aux_valid = 1'b0;
    settle();
    chk("t2_r8_addr", 32'(rf_addr), 8);
    chk("t2_r8_data", rf_data, 32'hB);
    chk("t2_pend_b",  32'(pending_cnt), 1);
    chk("t2_busy7b",  32'(rd_busy1), 0);
    chk("t2_busy8b",  32'(rd_busy2), 1);
    cyc();
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    settle();
    chk("t2_done_we", 32'(rf_we), 0);
    chk("t2_done_idle", 32'(idle), 1);

    // 3: WB holds r2 while AUX fills the FIFO with r3..r6
    for (int k = 0; k < 4; k++) begin
      wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
      aux_valid = 1'b1; aux_addr = 5'(3 + k); aux_data = 32'h30 + 32'(k);
      settle();
      chk("t3_ready", 32'(aux_ready), 1);
      chk("t3_wb_addr", 32'(rf_addr), 2);
      cyc();
    end
    wb_we = 1'b0; aux_addr = 5'd20; aux_data = 32'hBAD;
    settle();
    chk("t3_full_ready", 32'(aux_ready), 0);
    chk("t3_full_cnt",   32'(pending_cnt), 4);
    chk("t3_r3_addr",    32'(rf_addr), 3);
    chk("t3_r3_data",    rf_data, 32'h30);
    cyc();
    aux_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      settle();
      chk("t3_drain_we",   32'(rf_we), 1);
      chk("t3_drain_addr", 32'(rf_addr), 32'(3 + k));
      chk("t3_drain_data", rf_data, 32'h30 + 32'(k));
      cyc();
    end
    settle();
    chk("t3_idle", 32'(idle), 1);
    chk("t3_no_r20", 32'(rf_we), 0);

    // 4: WB to r9 kills the queued r9 entry at head
    aux_valid = 1'b1; aux_addr = 5'd9; aux_data = 32'h1;
    cyc();
    aux_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h2; rd_addr1 = 5'd9;
    settle();
    chk("t4_wb_addr", 32'(rf_addr), 9);
    chk("t4_wb_data", rf_data, 32'h2);
    chk("t4_busy",    32'(rd_busy1), 1);
    cyc();
    wb_we = 1'b0;
    settle();
    chk("t4_kill_we",   32'(rf_we), 0);
    chk("t4_kill_busy", 32'(rd_busy1), 0);
    chk("t4_kill_cnt",  32'(pending_cnt), 1);
    cyc();
    settle();
    chk("t4_after_cnt", 32'(pending_cnt), 0);
    chk("t4_after_we",  32'(rf_we), 0);
    rd_addr1 = 5'd0;

    // 5: starvation of r10 behind continuous WB writes
    aux_valid = 1'b1; aux_addr = 5'd10; aux_data = 32'h10A;
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    settle();
    chk("t5_push_stall", 32'(stall_req), 0);
    cyc();
    aux_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk("t5_no_stall", 32'(stall_req), 0);
      chk("t5_wb_wins",  32'(rf_addr), 1);
      cyc();
    end
    settle();
    chk("t5_stall", 32'(stall_req), 1);
    cyc();
    settle();
    chk("t5_ignored_addr",  32'(rf_addr), 1);
    chk("t5_ignored_stall", 32'(stall_req), 1);
    cyc();
    wb_we = 1'b0;
    settle();
    chk("t5_grant_addr", 32'(rf_addr), 10);
    chk("t5_grant_data", rf_data, 32'h10A);
    cyc();
    settle();
    chk("t5_stall_clr", 32'(stall_req), 0);
    chk("t5_idle",      32'(idle), 1);

    // 6: $0 discard, then reset drops queued entries
    aux_valid = 1'b1; aux_addr = 5'd0; aux_data = 32'hDEAD;
    settle();
    chk("t6_r0_ready", 32'(aux_ready), 1);
    cyc();
    aux_valid = 1'b0;
    settle();
    chk("t6_r0_cnt", 32'(pending_cnt), 0);
    chk("t6_r0_we",  32'(rf_we), 0);
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h99;
    for (int k = 0; k < 3; k++) begin
      aux_valid = 1'b1; aux_addr = 5'(11 + k); aux_data = 32'h100 + 32'(k);
      cyc();
    end
    aux_valid = 1'b0;
    settle();
    chk("t6_cnt3", 32'(pending_cnt), 3);
    reset = 1'b1; wb_we = 1'b0; rd_addr1 = 5'd11;
    settle();
    chk("t6_rst_we",    32'(rf_we), 0);
    chk("t6_rst_cnt",   32'(pending_cnt), 0);
    chk("t6_rst_idle",  32'(idle), 1);
    chk("t6_rst_busy",  32'(rd_busy1), 0);
    chk("t6_rst_ready", 32'(aux_ready), 0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t6_post_we",   32'(rf_we), 0);
      chk("t6_post_idle", 32'(idle), 1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two requesters.
- The pipeline writeback stage (WB) has fixed priority and is never back-pressured.
- An auxiliary requester (AUX; multi-cycle unit or loader) is buffered in a small FIFO and uses valid/ready.
- Sits between the WB stage and the register file. Also provides a pending-write scoreboard so decode can stall on registers with queued AUX writes.

Parameters:
- DEPTH, 4, AUX FIFO entries (power of 2, 2..8).
- STARVE_LIMIT, 8, cycles an AUX head entry may wait before stall_req asserts.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous active-high reset.
- wb_we  input  1  WB write request.
- wb_addr  input  5  WB destination register.
- wb_data  input  32  WB write data.
- aux_valid  input  1  AUX write request valid.
- aux_ready  output  1  AUX request accepted this cycle when high with aux_valid.
- aux_addr  input  5  AUX destination register.
- aux_data  input  32  AUX write data.
- rf_we  output  1  register-file write enable.
- rf_addr  output  5  register-file write address.
- rf_data  output  32  register-file write data.
- rd_addr1  input  5  decode source register 1 query.
- rd_addr2  input  5  decode source register 2 query.
- rd_busy1  output  1  live queued AUX write to rd_addr1.
- rd_busy2  output  1  live queued AUX write to rd_addr2.
- stall_req  output  1  AUX starving; pipeline must hold wb_we low next cycle.
- pending_cnt  output  4  number of occupied FIFO entries, live or killed.
- idle  output  1  FIFO empty.

Behaviour:
- Synchronous active-high reset on clk:
  - FIFO empty, all entry live bits 0, age counter 0.
  - While reset is high: aux_ready=0, rf_we=0, stall_req=0, rd_busy1/2=0, pending_cnt=0, idle=1.
- Accept:
  - Push on aux_valid && aux_ready; aux_ready = !full.
  - AUX writes to $0 are accepted and discarded (not pushed).
- Write port is combinational, zero latency:
  - wb_valid = wb_we && wb_addr!=0.
  - If wb_valid: rf_* = wb_*.
  - Else if head live: rf_* = head entry, pop.
  - Else: rf_we=0, rf_addr/rf_data=0.
- Killed head: popped without asserting rf_we. The port stays idle that cycle and the next entry waits one cycle.
- WAW ordering:
  - On a wb_valid write to register r, every live FIFO entry with addr r has its live bit cleared that same edge (WB is newer).
  - An AUX entry pushed in the same cycle as a WB write to the same r stays live (AUX is newer) and is written later.
- Simultaneous push and pop while full: not allowed, since aux_ready=0 when full. Push and pop together at other occupancies leaves the count unchanged.
- Age counter:
  - Counts cycles the head is live and not popped.
  - Cleared on pop, on empty, or when the head is killed.
  - Saturates at STARVE_LIMIT.
- stall_req = head live && age >= STARVE_LIMIT.
  - Contract: the pipeline deasserts wb_we in the following cycle, and the head is granted in that cycle.
  - If wb_we is asserted anyway, WB still wins and stall_req stays high.
- Scoreboard:
  - rd_busyN = (rd_addrN != 0) && any live entry with addr == rd_addrN.
  - Combinational on current state. An entry pushed this cycle is visible next cycle.
  - The entry popped this cycle still reads busy this cycle.
- pending_cnt = occupancy; idle = (occupancy == 0).
- Pointer wrap: pointers are log2(DEPTH) bits, wrap modulo DEPTH; full/empty is tracked by a separate count register.
- Reset mid-operation: queued entries are dropped, with no register-file writes during or after the reset cycle.

Test Plan:
1. Reset, then wb_we=1, wb_addr=5, wb_data=0x11 with no AUX -> same cycle rf_we=1, rf_addr=5, rf_data=0x11; idle=1.
2. AUX pushes r7=0xA, r8=0xB on consecutive cycles, wb_we=0 -> r7 written on the cycle after its push, then r8; during queueing rd_addr1=7 gives rd_busy1=1; pending_cnt peaks at 1.
3. wb_we held high to r2 for 4 cycles while AUX pushes r3..r6 -> aux_ready drops after the 4th push; rf_addr=2 on all 4 cycles; after wb_we drops, r3,r4,r5,r6 are written in order on 4 consecutive cycles.
4. Queue r9=0x1 and hold wb_we to r9=0x2 in the same cycle the entry is at head -> rf writes r9=0x2; the killed entry is popped with rf_we=0; rd_busy for r9 falls; r9 is never written 0x1.
5. AUX entry r10 queued, wb_we held continuously to r1 -> stall_req rises exactly STARVE_LIMIT=8 cycles after r10 reaches head; when wb_we drops next cycle, rf writes r10 and stall_req clears.
6. AUX push to r0 -> aux_ready=1, no entry, pending_cnt stays 0. Then with 3 entries queued, assert reset for 1 cycle -> pending_cnt=0, idle=1, and no rf_we for those entries afterwards.
